avalon_mem_test_master: RTL and testbench
=========================================

AVALON_MEM_TEST_MASTER -- requirements
Module: avalon_mem_test_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the target memory port.
REQ-002 SHALL have parameter DATA_W, default 32, data width of the target memory port; byteenable width is DATA_W/8.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  begin test; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate an active test.
REQ-007 SHALL have port base  input  ADDR_W  first word address, sampled with start.
REQ-008 SHALL have port count  input  ADDR_W+1  word count 0..2^ADDR_W, sampled with start.
REQ-009 SHALL have port pattern  input  DATA_W  fill pattern, sampled with start.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port pass  output  1  last test result, held until next accepted start.
REQ-013 SHALL have port err_count  output  ADDR_W+1  mismatches in last test.
REQ-014 SHALL have port first_err_addr  output  ADDR_W  address of first mismatch; 0 if none.
REQ-015 SHALL have ports address (output, ADDR_W), byteenable (output, DATA_W/8), chipselect (output, 1), write (output, 1), writedata (output, DATA_W), clken (output, 1), readdata (input, DATA_W) as master of a single-port synchronous memory with fixed read latency 1.

Function
REQ-016 SHALL implement states IDLE, WRITE, READ, DRAIN, DONE.
REQ-017 SHALL, in IDLE with start=1 and count!=0, latch base/count/pattern, clear err_count/first_err_addr/pass, and enter WRITE.
REQ-018 SHALL, in IDLE with start=1 and count=0, enter DONE directly with pass=1, err_count=0.
REQ-019 SHALL, in WRITE, drive chipselect=1, write=1, byteenable all ones, one word per cycle at address base+i, i=0..count-1, then enter READ.
REQ-020 SHALL compute addresses modulo 2^ADDR_W (base+i wraps to 0).
REQ-021 SHALL, in READ, drive chipselect=1, write=0, one address per cycle in the same order, then enter DRAIN for one cycle.
REQ-022 SHALL compare readdata in the cycle after each read address (READ cycles 2..N and DRAIN) against that address's expected word.
REQ-023 SHALL, on mismatch, increment err_count and, if it was 0, record first_err_addr.
REQ-024 SHALL drive chipselect=0, write=0 in IDLE, DRAIN, DONE.
REQ-025 SHALL hold clken=1 always.
REQ-026 SHALL, in DONE, assert done for exactly one cycle, set pass=(err_count==0) including the final DRAIN comparison, and return to IDLE.
REQ-027 SHALL give start-to-done latency of 2*count+2 cycles for count>=1 (done high in cycle 2N+2 after start sample cycle 0).
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL, on abort=1 in WRITE/READ/DRAIN, deassert chipselect next cycle, enter DONE with pass=0, err_count preserved; abort has priority over same-cycle transitions; abort in IDLE/DONE has no effect.

Reset
REQ-030 SHALL, while reset_n=0, force state IDLE, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, chipselect=0, write=0, address=0, writedata=0, byteenable=0.
REQ-031 SHALL, on reset mid-test, abandon the test without a done pulse; first accepted start after reset starts fresh.

Configuration
REQ-032 SHALL, with ADDR_XOR_EN defined, use expected/write word = pattern XOR zero-extended address.
REQ-033 SHALL, without ADDR_XOR_EN, use expected/write word = pattern for every address.

Verification
REQ-034 SHALL cover: base=0, count=1024, pattern=32'hA5A5A5A5, ideal memory -> done at cycle 2050, pass=1, err_count=0.
REQ-035 SHALL cover: base=1020, count=8 -> write addresses 1020..1023,0..3 in order, pass=1.
REQ-036 SHALL cover: memory model flips bit 0 at addresses 5 and 9, base=0, count=16 -> err_count=2, first_err_addr=5, pass=0.
REQ-037 SHALL cover: count=0 -> no chipselect activity, done 1 cycle after start, pass=1.
REQ-038 SHALL cover: abort in 3rd READ cycle of count=10 -> chipselect low next cycle, done pulse, pass=0; start during busy ignored.
REQ-039 SHALL cover: ADDR_XOR_EN defined, pattern=0, base=3, count=2 -> writedata 32'h3 then 32'h4, pass=1.

Source files
------------

// File: rtl/avalon_mem_test_master.sv
// Avalon memory test master: writes a pattern to a window of a single-port
// synchronous memory (read latency 1), reads it back and counts mismatches.
// Optional feature macro: ADDR_XOR_EN (write/expected word = pattern ^ address).
module avalon_mem_test_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     base,
    input  logic [ADDR_W:0]       count,
    input  logic [DATA_W-1:0]     pattern,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_W:0]       err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [ADDR_W-1:0]     address,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic                  chipselect,
    output logic                  write,
    output logic [DATA_W-1:0]     writedata,
    output logic                  clken,
    input  logic [DATA_W-1:0]     readdata
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   base_r;
    logic [ADDR_W:0]     cnt_r;
    logic [ADDR_W:0]     idx;
    logic [DATA_W-1:0]   pat_r;
    logic                rd_vld;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   cur_addr;
    logic                last_word;
    logic                accept;
    logic                err_hit;
    logic [ADDR_W:0]     err_nxt;

    // Word written to / expected from a given address.
    function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
`ifdef ADDR_XOR_EN
        word_of = pat_r ^ DATA_W'(a);
`else
        word_of = pat_r;
`endif
    endfunction

    // Address arithmetic wraps naturally at ADDR_W bits.
    assign cur_addr  = base_r + idx[ADDR_W-1:0];
    assign last_word = (idx == cnt_r - (ADDR_W+1)'(1));
    assign accept    = (state == IDLE) && start;
    // Readdata lags the address by one cycle; an aborting cycle is not scored.
    assign err_hit   = rd_vld && !abort && ((state == READ) || (state == DRAIN)) &&
                       (readdata != word_of(rd_addr));
    assign err_nxt   = err_count + (ADDR_W+1)'(err_hit);

    // Next-state and memory port outputs.
    always_comb begin
        state_nxt  = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        chipselect = (state == WRITE) || (state == READ);
        write      = (state == WRITE);
        address    = chipselect ? cur_addr : '0;
        byteenable = chipselect ? '1 : '0;
        writedata  = (state == WRITE) ? word_of(cur_addr) : '0;
        clken      = 1'b1;
        case (state)
            IDLE:  if (start) state_nxt = (count == '0) ? DONE : WRITE;
            WRITE: if (abort) state_nxt = DONE; else if (last_word) state_nxt = READ;
            READ:  if (abort) state_nxt = DONE; else if (last_word) state_nxt = DRAIN;
            DRAIN: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Test parameters, word index and read-compare pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_r  <= '0;
            cnt_r   <= '0;
            pat_r   <= '0;
            idx     <= '0;
            rd_vld  <= 1'b0;
            rd_addr <= '0;
        end else begin
            if (accept) begin
                base_r <= base;
                cnt_r  <= count;
                pat_r  <= pattern;
            end
            if ((state == WRITE) || (state == READ))
                idx <= last_word ? '0 : idx + (ADDR_W+1)'(1);
            else
                idx <= '0;
            rd_vld  <= (state == READ) && !abort;
            rd_addr <= cur_addr;
        end
    end

    // Result registers: error count, first failing address, pass flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
        end else if (accept) begin
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= (count == '0);
        end else begin
            if (err_hit) begin
                err_count <= err_nxt;
                if (err_count == '0) first_err_addr <= rd_addr;
            end
            if (((state == WRITE) || (state == READ) || (state == DRAIN)) && state_nxt == DONE)
                pass <= !abort && (err_nxt == '0);
        end
    end

endmodule

// File: tb/tb_avalon_mem_test_master.sv
// Directed bench for avalon_mem_test_master with a latency-1 memory model.
module tb_avalon_mem_test_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [9:0]  base = '0;
    logic [10:0] count = '0;
    logic [31:0] pattern = '0;
    logic        busy, done, pass, chipselect, write, clken;
    logic [10:0] err_count;
    logic [9:0]  first_err_addr, address;
    logic [3:0]  byteenable;
    logic [31:0] writedata, readdata;

    avalon_mem_test_master #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base(base), .count(count), .pattern(pattern),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .address(address),
        .byteenable(byteenable), .chipselect(chipselect), .write(write),
        .writedata(writedata), .clken(clken), .readdata(readdata)
    );

    always #5 clk = ~clk;

    // Memory model with optional bit-0 fault on reads of addresses 5 and 9.
    logic [31:0] mem [0:1023];
    bit          flip_en = 1'b0;
    logic [9:0]  wq[$], rq[$];
    logic [31:0] dq[$];
    int          done_n = 0;

    always @(posedge clk) begin
        if (done) done_n++;
        if (chipselect) begin
            if (write) begin
                mem[address] <= writedata;
                wq.push_back(address);
                dq.push_back(writedata);
            end else begin
                readdata <= mem[address] ^ ((flip_en && (address == 10'd5 || address == 10'd9)) ? 32'd1 : 32'd0);
                rq.push_back(address);
            end
        end
    end

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ew(input logic [31:0] p, input logic [9:0] a);
`ifdef ADDR_XOR_EN
        ew = p ^ {22'd0, a};
`else
        ew = p;
`endif
    endfunction

    typedef struct {
        logic [9:0]  base;
        logic [10:0] cnt;
        logic [31:0] pat;
        bit          flip;
        int          lat;
        bit          pass;
        int          err;
        logic [9:0]  first;
    } vec_t;

    // Runs one test from a negedge; leaves the bench at a negedge.
    task automatic run(input vec_t v, input string nm);
        int lat, bad_a, bad_r, bad_d;
        wq.delete(); rq.delete(); dq.delete();
        base = v.base; count = v.cnt; pattern = v.pat; flip_en = v.flip;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, v.lat);
        chk({nm, " pass"}, pass, v.pass);
        chk({nm, " err_count"}, err_count, v.err);
        chk({nm, " first_err_addr"}, first_err_addr, v.first);
        chk({nm, " busy in done"}, busy, 1);
        chk({nm, " writes"}, wq.size(), v.cnt);
        chk({nm, " reads"}, rq.size(), v.cnt);
        bad_a = 0; bad_r = 0; bad_d = 0;
        foreach (wq[i]) begin
            if (wq[i] !== 10'(v.base + 10'(i))) bad_a++;
            if (dq[i] !== ew(v.pat, 10'(v.base + 10'(i)))) bad_d++;
        end
        foreach (rq[i]) if (rq[i] !== 10'(v.base + 10'(i))) bad_r++;
        chk({nm, " write addr order"}, bad_a, 0);
        chk({nm, " read addr order"}, bad_r, 0);
        chk({nm, " write data"}, bad_d, 0);
        @(negedge clk);
        chk({nm, " done one cycle"}, {busy, done}, 2'b00);
        chk({nm, " pass held"}, pass, v.pass);
    endtask

    vec_t vt[6];

    initial begin
        int lat;
        vt[0] = '{10'd0,    11'd1024, 32'hA5A5A5A5, 1'b0, 2050, 1'b1, 0, 10'd0};
        vt[1] = '{10'd1020, 11'd8,    32'h12345678, 1'b0, 18,   1'b1, 0, 10'd0};
        vt[2] = '{10'd0,    11'd16,   32'hFFFF0000, 1'b1, 34,   1'b0, 2, 10'd5};
        vt[3] = '{10'd5,    11'd0,    32'h0,        1'b0, 1,    1'b1, 0, 10'd0};
        vt[4] = '{10'd1023, 11'd1,    32'hDEADBEEF, 1'b0, 4,    1'b1, 0, 10'd0};
        vt[5] = '{10'd3,    11'd2,    32'h0,        1'b0, 6,    1'b1, 0, 10'd0};

        // Reset state.
        #12;
        chk("reset outputs", {busy, done, pass, err_count, first_err_addr, chipselect,
                              write, address, writedata, byteenable},
            '0);
        chk("reset clken", clken, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run(vt[i], $sformatf("vec%0d", i));

`ifdef ADDR_XOR_EN
        // XOR mode: pattern 0, base 3 -> writedata 3 then 4.
        run(vt[5], "xor");
        chk("xor wd0", dq[0], 32'h3);
        chk("xor wd1", dq[1], 32'h4);
`endif

        // Abort in the 3rd READ cycle of a 10-word test, with start held high.
        wq.delete(); rq.delete();
        base = 10'd0; count = 11'd10; pattern = 32'h0F0F0F0F; flip_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (lat < 13) begin
            @(negedge clk);
            lat++;
        end
        chk("abort read active", {chipselect, write, done}, 3'b100);
        abort = 1'b1; start = 1'b1; count = 11'd5;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort cs low", chipselect, 0);
        chk("abort done", done, 1);
        chk("abort pass", pass, 0);
        chk("abort err kept", err_count, 0);
        @(negedge clk);
        chk("abort back idle", {busy, done}, 2'b00);
        chk("abort writes", wq.size(), 10);
        chk("abort reads", rq.size(), 3);

        // Abort while idle must do nothing.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle abort", {busy, done}, 2'b00);

        // Reset mid-test: no done pulse, next start is fresh.
        base = 10'd100; count = 11'd20; pattern = 32'h55AA55AA;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        done_n = 0;
        reset_n = 1'b0;
        #1;
        chk("midreset outputs", {busy, done, chipselect, write, address, err_count}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (45) @(negedge clk);
        chk("midreset no done", done_n, 0);
        run(vt[2], "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
